// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a decoupled prefetch FIFO in front of ID.
// Fetches are credit-limited so every in-flight response always has a free slot.
module if_fetch_queue #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               branch_i,
  input  logic [ADDR_WIDTH-1:0]              branch_addr_i,
  input  logic                               jump_i,
  input  logic [ADDR_WIDTH-1:0]              jump_addr_i,
  output logic                               im_req_o,
  output logic [ADDR_WIDTH-1:0]              im_addr_o,
  input  logic                               im_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              im_rdata_i,
  output logic                               inst_valid_o,
  output logic [DATA_WIDTH-1:0]              inst_o,
  output logic [ADDR_WIDTH-1:0]              inst_pc_o,
  output logic [ADDR_WIDTH-1:0]              inst_pc_plus1_o,
  input  logic                               id_ready_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_o,
  output logic                               processor_status_o
);

  localparam int CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int SW  = CW + 1;
  localparam int PW  = $clog2(QUEUE_DEPTH);
  // Back-to-back redirects can stack several windows of stale responses.
  localparam int DCW = $clog2(4 * QUEUE_DEPTH + 1);

  logic                  status_q, status_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [DCW-1:0]        discard_q, discard_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] data_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];

  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;
  logic [SW-1:0]         credit_sum;
  logic                  issue;
  logic                  resp_live;
  logic                  resp_drop;
  logic                  push;
  logic                  pop;
  logic                  head_valid;

  assign redirect   = branch_i | jump_i;
  assign target     = branch_i ? branch_addr_i : jump_addr_i;
  assign credit_sum = SW'(count_q) + SW'(outst_q);
  assign issue      = status_q & ~redirect & (credit_sum < SW'(QUEUE_DEPTH));
  assign resp_live  = im_rvalid_i & (discard_q == '0);
  assign resp_drop  = im_rvalid_i & (discard_q != '0);
  assign push       = resp_live & ~redirect;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & id_ready_i & ~redirect;

  // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    status_d   = status_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (stop)       status_d = 1'b0;
    else if (start) status_d = 1'b1;

    if (redirect) begin
      // Everything still in flight becomes stale; the response landing now is one of them.
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = '0;
      discard_d  = discard_q + DCW'(outst_q) - DCW'(im_rvalid_i);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      outst_d   = outst_q + CW'(issue) - CW'(resp_live);
      discard_d = discard_q - DCW'(resp_drop);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      status_q   <= status_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= im_rdata_i;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign im_req_o           = issue;
  assign im_addr_o          = fetch_pc_q;
  assign inst_valid_o       = head_valid;
  // Head fields are forced to zero while empty so unwritten storage never leaks out.
  assign inst_o             = head_valid ? data_mem[rd_ptr_q] : '0;
  assign inst_pc_o          = head_valid ? pc_mem[rd_ptr_q] : '0;
  assign inst_pc_plus1_o    = head_valid ? pc_mem[rd_ptr_q] + ADDR_WIDTH'(1) : '0;
  assign queue_count_o      = count_q;
  assign processor_status_o = status_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a fixed-latency in-order instruction memory.
// Memory word at address a is {~a, a}, so every delivered instruction identifies its PC.
module tb_if_fetch_queue;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int QD = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          branch_i;
  logic [AW-1:0] branch_addr_i;
  logic          jump_i;
  logic [AW-1:0] jump_addr_i;
  logic          im_req_o;
  logic [AW-1:0] im_addr_o;
  logic          im_rvalid_i;
  logic [DW-1:0] im_rdata_i;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic [AW-1:0] inst_pc_plus1_o;
  logic          id_ready_i;
  logic [CW-1:0] queue_count_o;
  logic          processor_status_o;

  int errors;
  int checks;
  int lat;

  if_fetch_queue #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .QUEUE_DEPTH(QD),
    .RESET_PC   (8'h00)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .stop              (stop),
    .branch_i          (branch_i),
    .branch_addr_i     (branch_addr_i),
    .jump_i            (jump_i),
    .jump_addr_i       (jump_addr_i),
    .im_req_o          (im_req_o),
    .im_addr_o         (im_addr_o),
    .im_rvalid_i       (im_rvalid_i),
    .im_rdata_i        (im_rdata_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o),
    .inst_pc_plus1_o   (inst_pc_plus1_o),
    .id_ready_i        (id_ready_i),
    .queue_count_o     (queue_count_o),
    .processor_status_o(processor_status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] idata(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // Instruction memory: delay line, response appears lat cycles after the request.
  logic [3:0]    pv;
  logic [AW-1:0] pa [4];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < 4; k++) pa[k] <= '0;
    end else begin
      pv    <= {pv[2:0], im_req_o};
      pa[0] <= im_addr_o;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end

  assign im_rvalid_i = pv[lat-1];
  assign im_rdata_i  = idata(pa[lat-1]);

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    branch_i = 1'b0; jump_i = 1'b0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat = 1; id_ready_i = 1'b1;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    branch_i = 1'b0; jump_i = 1'b0; branch_addr_i = '0; jump_addr_i = '0;
    next();
    next();
    #1;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", im_req_o); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", queue_count_o); end
    checks++; if (processor_status_o !== 1'b0) begin errors++; $display("FAIL reset_status: got %b expected 0", processor_status_o); end
    checks++; if (im_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", im_addr_o); end
    checks++; if (inst_o !== 16'h0000) begin errors++; $display("FAIL reset_inst: got %h expected 0000", inst_o); end
    rst = 1'b0; start = 1'b1; stop = 1'b1;
    next();
    checks++; if (processor_status_o !== 1'b0) begin errors++; $display("FAIL stop_beats_start: got %b expected 0", processor_status_o); end
    stop = 1'b0;
    next();
    start = 1'b0;
    checks++; if (processor_status_o !== 1'b1) begin errors++; $display("FAIL start_sets: got %b expected 1", processor_status_o); end
  endtask

  task automatic test_stream();
    lat = 1; id_ready_i = 1'b1;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'(i)) begin errors++; $display("FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, im_req_o, im_addr_o, 8'(i)); end
      if (i < 2) begin
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stream_fill[%0d]: got valid=%b expected 0", i, inst_valid_o); end
      end else begin
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'(i-2) || inst_pc_plus1_o !== 8'(i-1) || inst_o !== idata(8'(i-2))) begin
          errors++;
          $display("FAIL stream_head[%0d]: got v=%b pc=%h pc1=%h inst=%h expected v=1 pc=%h pc1=%h inst=%h",
                   i, inst_valid_o, inst_pc_o, inst_pc_plus1_o, inst_o, 8'(i-2), 8'(i-1), idata(8'(i-2)));
        end
      end
      next();
    end
  endtask

  task automatic test_stall();
    int reqs;
    lat = 1; id_ready_i = 1'b0;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (im_req_o) reqs++;
      next();
    end
    #1;
    checks++; if (reqs != 4) begin errors++; $display("FAIL stall_reqs: got %0d expected 4", reqs); end
    checks++; if (queue_count_o !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", queue_count_o); end
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL stall_req_off: got %b expected 0", im_req_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h00 || inst_o !== idata(8'h00)) begin errors++; $display("FAIL stall_head: got v=%b pc=%h inst=%h expected v=1 pc=00 inst=%h", inst_valid_o, inst_pc_o, inst_o, idata(8'h00)); end
    id_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'(k)) begin errors++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, inst_valid_o, inst_pc_o, 8'(k)); end
      next();
    end
  endtask

  task automatic test_branch_discard();
    int first;
    lat = 3; id_ready_i = 1'b1;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    next();
    next();
    next();
    branch_i = 1'b1; branch_addr_i = 8'h40;
    #1;
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL branch_no_issue: got %b expected 0", im_req_o); end
    next();
    branch_i = 1'b0;
    first = -1;
    for (int idx = 0; idx < 10; idx++) begin
      #1;
      if (idx == 0) begin
        checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h40) begin errors++; $display("FAIL branch_target_req: got req=%b addr=%h expected req=1 addr=40", im_req_o, im_addr_o); end
        checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL branch_flush: got %0d expected 0", queue_count_o); end
      end
      if (inst_valid_o && first < 0) begin
        first = idx;
        checks++; if (idx != 4) begin errors++; $display("FAIL branch_first_cycle: got %0d expected 4", idx); end
        checks++; if (inst_pc_o !== 8'h40 || inst_o !== idata(8'h40)) begin errors++; $display("FAIL branch_first_inst: got pc=%h inst=%h expected pc=40 inst=%h", inst_pc_o, inst_o, idata(8'h40)); end
      end
      next();
      if (first >= 0) break;
    end
    checks++; if (first < 0) begin errors++; $display("FAIL branch_timeout: got no valid instruction expected one within 10 cycles"); end
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h41) begin errors++; $display("FAIL branch_second_inst: got v=%b pc=%h expected v=1 pc=41", inst_valid_o, inst_pc_o); end
  endtask

  task automatic test_priority();
    lat = 1; id_ready_i = 1'b1;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    next();
    next();
    next();
    branch_i = 1'b1; branch_addr_i = 8'h20;
    jump_i   = 1'b1; jump_addr_i   = 8'h80;
    next();
    branch_i = 1'b0; jump_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h20) begin errors++; $display("FAIL prio_target: got req=%b addr=%h expected req=1 addr=20", im_req_o, im_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL prio_flushed: got %b expected 0", inst_valid_o); end
    next();
    next();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h20) begin errors++; $display("FAIL prio_head: got v=%b pc=%h expected v=1 pc=20", inst_valid_o, inst_pc_o); end
    jump_i = 1'b1; jump_addr_i = 8'h80;
    next();
    jump_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h80) begin errors++; $display("FAIL jump_target: got req=%b addr=%h expected req=1 addr=80", im_req_o, im_addr_o); end
    next();
    next();
    checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 8'h80 || inst_o !== idata(8'h80)) begin errors++; $display("FAIL jump_head: got v=%b pc=%h inst=%h expected v=1 pc=80 inst=%h", inst_valid_o, inst_pc_o, inst_o, idata(8'h80)); end
  endtask

  task automatic test_wrap();
    lat = 1; id_ready_i = 1'b1;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    next();
    jump_i = 1'b1; jump_addr_i = 8'hFE;
    next();
    jump_i = 1'b0;
    #1;
    checks++; if (im_addr_o !== 8'hFE) begin errors++; $display("FAIL wrap_addr_fe: got %h expected fe", im_addr_o); end
    next();
    checks++; if (im_addr_o !== 8'hFF) begin errors++; $display("FAIL wrap_addr_ff: got %h expected ff", im_addr_o); end
    next();
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h00) begin errors++; $display("FAIL wrap_addr_00: got req=%b addr=%h expected req=1 addr=00", im_req_o, im_addr_o); end
    checks++; if (inst_pc_o !== 8'hFE || inst_pc_plus1_o !== 8'hFF) begin errors++; $display("FAIL wrap_head_fe: got pc=%h pc1=%h expected pc=fe pc1=ff", inst_pc_o, inst_pc_plus1_o); end
    next();
    checks++; if (inst_pc_o !== 8'hFF || inst_pc_plus1_o !== 8'h00 || inst_o !== idata(8'hFF)) begin errors++; $display("FAIL wrap_head_ff: got pc=%h pc1=%h inst=%h expected pc=ff pc1=00 inst=%h", inst_pc_o, inst_pc_plus1_o, inst_o, idata(8'hFF)); end
    next();
    checks++; if (inst_pc_o !== 8'h00 || inst_pc_plus1_o !== 8'h01) begin errors++; $display("FAIL wrap_head_00: got pc=%h pc1=%h expected pc=00 pc1=01", inst_pc_o, inst_pc_plus1_o); end
  endtask

  task automatic test_stop();
    int reqs;
    int delivered;
    lat = 2; id_ready_i = 1'b1;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h00) begin errors++; $display("FAIL stop_req0: got req=%b addr=%h expected req=1 addr=00", im_req_o, im_addr_o); end
    next();
    stop = 1'b1;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 8'h01) begin errors++; $display("FAIL stop_req1: got req=%b addr=%h expected req=1 addr=01", im_req_o, im_addr_o); end
    next();
    stop = 1'b0;
    checks++; if (processor_status_o !== 1'b0) begin errors++; $display("FAIL stop_status: got %b expected 0", processor_status_o); end
    reqs = 0;
    delivered = 0;
    for (int idx = 0; idx < 8; idx++) begin
      #1;
      if (im_req_o) reqs++;
      if (inst_valid_o) begin
        checks++; if (inst_pc_o !== 8'(delivered)) begin errors++; $display("FAIL stop_deliver[%0d]: got pc=%h expected %h", delivered, inst_pc_o, 8'(delivered)); end
        delivered++;
      end
      next();
    end
    checks++; if (reqs != 0) begin errors++; $display("FAIL stop_no_issue: got %0d requests expected 0", reqs); end
    checks++; if (delivered != 2) begin errors++; $display("FAIL stop_delivered: got %0d expected 2", delivered); end
  endtask

  task automatic test_reset_mid();
    lat = 1; id_ready_i = 1'b0;
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    next();
    next();
    next();
    checks++; if (queue_count_o !== 3'd2) begin errors++; $display("FAIL mid_count_before: got %0d expected 2", queue_count_o); end
    rst = 1'b1;
    next();
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid_o !== 1'b0 || im_req_o !== 1'b0 || queue_count_o !== 3'd0 || processor_status_o !== 1'b0 ||
        inst_o !== 16'h0000 || inst_pc_o !== 8'h00 || inst_pc_plus1_o !== 8'h00 || im_addr_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: got v=%b req=%b cnt=%0d st=%b inst=%h pc=%h pc1=%h addr=%h expected all zero",
               inst_valid_o, im_req_o, queue_count_o, processor_status_o, inst_o, inst_pc_o, inst_pc_plus1_o, im_addr_o);
    end
    next();
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got %b expected 0", im_req_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_discard();
    test_priority();
    test_wrap();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-register IF/ID path with a QUEUE_DEPTH-entry FIFO and issues pipelined requests to an instruction memory with variable, in-order response latency. It accepts branch/jump redirects, discards stale in-flight responses, and presents instructions to ID over a valid/ready handshake.

Parameters:
DATA_WIDTH, 16, instruction width
ADDR_WIDTH, 8, PC / instruction-memory address width
QUEUE_DEPTH, 4, prefetch FIFO entries (power of two, ≥2); also the cap on queued + outstanding fetches
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
start  in  1  sets processor status
stop  in  1  clears processor status
branch_i  in  1  branch redirect (highest priority)
branch_addr_i  in  ADDR_WIDTH  branch target
jump_i  in  1  jump redirect
jump_addr_i  in  ADDR_WIDTH  jump target
im_req_o  out  1  fetch request this cycle (always accepted)
im_addr_o  out  ADDR_WIDTH  fetch address
im_rvalid_i  in  1  response valid (in order, ≥1 cycle after request)
im_rdata_i  in  DATA_WIDTH  response instruction
inst_valid_o  out  1  queue head valid
inst_o  out  DATA_WIDTH  head instruction
inst_pc_o  out  ADDR_WIDTH  head PC
inst_pc_plus1_o  out  ADDR_WIDTH  head PC+1 (mod 2^ADDR_WIDTH)
id_ready_i  in  1  ID accepts head
queue_count_o  out  clog2(QUEUE_DEPTH+1)  valid entries
processor_status_o  out  1  running flag

Behaviour:
- Reset: status=0, fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0; all outputs 0 (inst_valid_o=0, im_req_o=0). Reset mid-operation drops all in-flight state; IM is reset on the same rst.
- Status register: rst or stop -> 0 (stop beats start); else start -> 1; else hold.
- Issue: im_req_o = status & ~redirect & (count + outstanding < QUEUE_DEPTH). im_addr_o = fetch_pc (combinational). On issue, fetch_pc <= fetch_pc+1 (wraps 2^ADDR_WIDTH-1 -> 0) and outstanding increments.
- Response: im_rvalid_i decrements outstanding (or discard, when discard>0). If discard==0, push {im_rdata_i, PC of that request} into the queue. Each queue entry's PC is tracked by a response-PC counter that follows the issue order.
- Credit rule: count + outstanding ≤ QUEUE_DEPTH always, so a push never overflows. Simultaneous push and pop are allowed, and count stays unchanged.
- Pop: inst_valid_o = (count≠0), first-word fall-through from registered storage. Pop when inst_valid_o & id_ready_i. id_ready_i low holds all head outputs stable.
- Redirect: redirect = branch_i | jump_i, with target = branch_i ? branch_addr_i : jump_addr_i.
  - Next edge: fetch_pc <= target; the queue is flushed (count=0, and a same-cycle pop or push is ignored).
  - discard <= discard + outstanding - im_rvalid_i; outstanding <= 0; no request issues in the redirect cycle.
  - The first request to the target issues the following cycle if status=1.
- Redirect with status=0: fetch_pc and the flush still apply; no issue follows until start.
- Stop: new issue ceases the cycle after stop. Outstanding responses still land, and the queue drains normally to ID.
- Back-to-back redirects: each flushes; discard accumulates correctly.
- Counters are sized to hold QUEUE_DEPTH without wrap.

Test Plan:
- Reset, start, IM latency 1, id_ready_i=1 -> im_addr_o issues 0,1,2,...; inst_pc_o 0,1,2 with inst_pc_plus1_o 1,2,3; one instruction per cycle after a 2-cycle fill.
- id_ready_i=0 with QUEUE_DEPTH=4 -> exactly 4 requests total; queue_count_o=4; im_req_o=0; head stays PC 0 until ready is raised.
- IM latency 3; branch_i=1 with branch_addr_i=0x40 while 3 requests are outstanding -> 3 responses dropped; next inst_pc_o=0x40; no stale instruction reaches ID.
- branch_i and jump_i in the same cycle (0x20 vs 0x80) -> fetch resumes at 0x20.
- fetch_pc at 0xFF, running -> next im_addr_o=0x00; inst_pc_plus1_o for PC 0xFF is 0x00.
- stop asserted with 2 outstanding -> no further requests; 2 responses delivered; processor_status_o=0; rst mid-stream -> all outputs 0 the next cycle.
